// File: rtl/rv_pkg.sv
// Constants shared by the fetch/decode front end: machine width and the canonical NOP.
package rv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

endpackage : rv_pkg

// File: rtl/if_id_queue.sv
// Fetch-to-decode skid queue: a small FIFO of {instr, pc} entries with flush and a NOP-filled idle output.
// Both ready/valid outputs are decoded from the registered occupancy only.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = rv_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     f_valid,
    output logic                     f_ready,
    input  logic [XLEN-1:0]          f_instr,
    input  logic [XLEN-1:0]          f_pc,

    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [XLEN-1:0]          d_instr,
    output logic [XLEN-1:0]          d_pc,
    output logic [XLEN-1:0]          d_pc_plus4,

    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    import rv_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];

    logic [CW-1:0]     count_q,  count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;

    logic              push;
    logic              pop;
    logic              mem_we;
    entry_t            head;

    assign f_ready = (count_q < CW'(DEPTH));
    assign d_valid = (count_q != '0);

    assign push = f_valid && f_ready;
    assign pop  = d_valid && d_ready;

    // Flush wins over any transfer presented in the same cycle.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_we   = 1'b0;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            mem_we   = push;
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage holds no reset; an empty count makes its contents invisible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= '{instr: f_instr, pc: f_pc};
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        d_instr = XLEN'(NOP_INSTR);
        d_pc    = '0;
        if (d_valid) begin
            d_instr = head.instr;
            d_pc    = head.pc;
        end
    end

    assign d_pc_plus4 = d_pc + XLEN'(4);
    assign count      = count_q;

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CW'(DEPTH));

    a_hold_stall : assert property (@(posedge clk) disable iff (!rst_n || flush)
        (d_valid && !d_ready) |=> (d_valid && $stable(d_instr) && $stable(d_pc)));

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_id_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid, f_ready, d_valid, d_ready, flush;
    logic [31:0] f_instr, f_pc, d_instr, d_pc, d_pc_plus4;
    logic [1:0]  count;

    int checks = 0;
    int passes = 0;
    bit check_en = 0;

    logic [63:0] model_q [$];

    if_id_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .f_instr    (f_instr),
        .f_pc       (f_pc),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .d_pc_plus4 (d_pc_plus4),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: a plain queue; transfers decided from the occupancy before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            bit do_push, do_pop;
            do_push = f_valid && (model_q.size() < DEPTH);
            do_pop  = d_ready && (model_q.size() != 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({f_instr, f_pc});
        end
    end

    task automatic check_model();
        logic [31:0] e_instr, e_pc;
        e_instr = NOP;
        e_pc    = 32'h0;
        if (model_q.size() != 0) begin
            e_instr = model_q[0][63:32];
            e_pc    = model_q[0][31:0];
        end
        chk("m_count",   32'(count),   32'(model_q.size()));
        chk("m_f_ready", 32'(f_ready), 32'(model_q.size() < DEPTH));
        chk("m_d_valid", 32'(d_valid), 32'(model_q.size() != 0));
        chk("m_d_instr", d_instr,      e_instr);
        chk("m_d_pc",    d_pc,         e_pc);
        chk("m_pc4",     d_pc_plus4,   e_pc + 32'd4);
    endtask

    always @(negedge clk) begin
        if (check_en) check_model();
    end

    task automatic idle();
        f_valid = 0; d_ready = 0; flush = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
        f_valid = 1; f_instr = ins; f_pc = pc;
        step();
        f_valid = 0;
    endtask

    task automatic drain();
        d_ready = 1;
        repeat (3) step();
        d_ready = 0;
    endtask

    logic [31:0] seq [9];

    initial begin
        rst_n = 0; f_valid = 0; d_ready = 0; flush = 0; f_instr = 0; f_pc = 0;
        step();
        check_en = 1;
        step();
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_f_ready", 32'(f_ready), 32'd1);
        chk("rst_d_instr", d_instr,      NOP);
        chk("rst_pc4",     d_pc_plus4,   32'd4);
        rst_n = 1;
        step();

        // Push into empty queue: invisible in the push cycle, visible next.
        f_valid = 1; f_instr = 32'h1234_5678; f_pc = 32'h200;
        #1 chk("lat_same_cycle", 32'(d_valid), 32'd0);
        step();
        f_valid = 0;
        chk("lat_next_valid", 32'(d_valid), 32'd1);
        chk("lat_next_instr", d_instr, 32'h1234_5678);
        drain();

        // Fill, then drain in order.
        push1(32'h0050_0093, 32'h100);
        push1(32'h00A0_0113, 32'h104);
        chk("fill_count",   32'(count),   32'd2);
        chk("fill_f_ready", 32'(f_ready), 32'd0);
        d_ready = 1;
        chk("drain0_instr", d_instr,    32'h0050_0093);
        chk("drain0_pc4",   d_pc_plus4, 32'h104);
        step();
        chk("drain1_instr", d_instr,    32'h00A0_0113);
        chk("drain1_pc4",   d_pc_plus4, 32'h108);
        step();
        d_ready = 0;
        chk("drain_empty", 32'(count), 32'd0);

        // Steady push+pop at count=1 for 8 cycles.
        for (int i = 0; i < 9; i++) seq[i] = 32'hA000_0000 + 32'(i);
        push1(seq[0], 32'h300);
        for (int i = 0; i < 8; i++) begin
            chk("pp_head", d_instr, seq[i]);
            f_valid = 1; d_ready = 1; f_instr = seq[i+1]; f_pc = 32'h304 + 32'(4*i);
            step();
            chk("pp_count", 32'(count), 32'd1);
        end
        idle();
        chk("pp_last", d_instr, seq[8]);
        drain();

        // Flush with two entries and a concurrent push.
        push1(32'h1111_1111, 32'h400);
        push1(32'h2222_2222, 32'h404);
        flush = 1; f_valid = 1; f_instr = 32'hDEAD_BEEF; f_pc = 32'h500;
        step();
        idle();
        chk("fl_count",   32'(count),   32'd0);
        chk("fl_d_valid", 32'(d_valid), 32'd0);
        chk("fl_f_ready", 32'(f_ready), 32'd1);
        step();
        chk("fl_no_ghost", 32'(d_valid), 32'd0);

        // PC wrap.
        push1(32'h0000_0013, 32'hFFFF_FFFC);
        chk("wrap_pc4", d_pc_plus4, 32'h0);
        drain();

        // Asynchronous reset mid-stream.
        push1(32'h3333_3333, 32'h600);
        push1(32'h4444_4444, 32'h604);
        chk("ar_pre_count", 32'(count), 32'd2);
        #2 rst_n = 0;
        #1;
        chk("ar_count",   32'(count),   32'd0);
        chk("ar_d_valid", 32'(d_valid), 32'd0);
        chk("ar_d_instr", d_instr,      NOP);
        chk("ar_f_ready", 32'(f_ready), 32'd1);
        step();
        rst_n = 1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            f_valid = ($urandom_range(0, 3) != 0);
            d_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            f_instr = $urandom;
            f_pc    = {$urandom, 2'b00} ;
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the number of entries; legal values are powers of two, 2 or greater.
REQ-002 SHALL have parameter XLEN, default 32, the instruction and PC width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port f_valid, input, 1 bit: fetch presents an instruction.
REQ-006 SHALL have port f_ready, output, 1 bit: the queue can accept an entry.
REQ-007 SHALL have port f_instr, input, XLEN bits: the fetched instruction word.
REQ-008 SHALL have port f_pc, input, XLEN bits: the PC of f_instr.
REQ-009 SHALL have port d_valid, output, 1 bit: the head entry is presented to decode.
REQ-010 SHALL have port d_ready, input, 1 bit: decode consumes the head entry.
REQ-011 SHALL have port d_instr, output, XLEN bits: the head instruction, driven to the sign extender and decoder.
REQ-012 SHALL have port d_pc, output, XLEN bits: the head PC.
REQ-013 SHALL have port d_pc_plus4, output, XLEN bits: d_pc + 4.
REQ-014 SHALL have port flush, input, 1 bit: branch or jump redirect; discards all entries.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-016 SHALL push when f_valid && f_ready at a rising edge and pop when d_valid && d_ready at a rising edge.
REQ-017 SHALL drive f_ready = (count < DEPTH), decoded from registered state only, with no combinational path from d_ready.
REQ-018 SHALL drive d_valid = (count != 0).
REQ-019 SHALL give a latency of 1 cycle from push to visibility: an entry pushed into an empty queue appears on d_* the next cycle, with no same-cycle bypass.
REQ-020 SHALL, on a simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-021 SHALL make a push impossible when full (f_ready=0) and a pop impossible when empty (d_valid=0); count never overflows or underflows.
REQ-022 SHALL wrap read and write pointers modulo DEPTH using natural binary rollover.
REQ-023 SHALL, when d_valid=0, drive d_instr = NOP (32'h00000013), d_pc = 0 and d_pc_plus4 = 4.
REQ-024 SHALL compute d_pc_plus4 as a modulo-2^XLEN add, so that 32'hFFFFFFFC yields 0.
REQ-025 SHALL give flush priority: in a flush cycle, count, the read pointer and the write pointer all become 0 next cycle, and any push or pop in that cycle is discarded.
REQ-026 SHALL drive f_ready=1 in the cycle after a flush.
REQ-027 SHALL hold d_* stable while d_valid=1 && d_ready=0.

Reset
REQ-028 SHALL, on rst_n low, immediately clear count and both pointers without waiting for clk.
REQ-029 SHALL drive these outputs during reset: f_ready=1, d_valid=0, d_instr=NOP, d_pc=0, d_pc_plus4=4, count=0.
REQ-030 SHALL discard all stored entries when reset asserts mid-operation; the storage array needs no reset.
REQ-031 SHALL make reset deassertion take effect at the next clk edge.

Structure
REQ-032 SHALL place XLEN and the NOP_INSTR constant in the shared package rv_pkg, where the decode stage also uses them.
REQ-033 SHALL be one flat module with no sub-module; storage is an inline array of {instr, pc} entries.
REQ-034 SHALL fit in 120-400 lines of RTL.

Verification
REQ-035 Reset check: assert rst_n=0 mid-stream with count=2 -> count=0, d_valid=0, d_instr=32'h00000013 and f_ready=1 immediately, before any clk edge.
REQ-036 Fill and drain: push 0x00500093 @ pc 0x100 and then 0x00A00113 @ pc 0x104 with d_ready=0 -> f_ready=0 and count=2; raise d_ready -> the two entries pop in order, with d_pc_plus4 equal to 0x104 and then 0x108.
REQ-037 Latency: push into an empty queue -> d_valid is 0 in the push cycle and 1 the next cycle.
REQ-038 Simultaneous push and pop at count=1 over 8 cycles -> count stays 1, pointers wrap, and the output sequence matches the input sequence.
REQ-039 Flush: assert flush with count=2 and f_valid=1 -> the next cycle has count=0, d_valid=0 and f_ready=1, and the dropped push never appears.
REQ-040 PC wrap: push pc=32'hFFFFFFFC -> d_pc_plus4 = 32'h00000000.
